// File: rtl/booth_mult_iter.sv
// Iterative radix-2 Booth signed multiplier: one add/sub-and-shift step per cycle,
// returning the low WIDTH product bits plus a signed-overflow flag.
module booth_mult_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned PW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } stateT;

    stateT            stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic [PW-1:0]    prodQ, prodD;
    logic [WIDTH-1:0] mcandQ, mcandD;
    logic [WIDTH-1:0] resultQ, resultD;
    logic             excQ, excD;

    logic [WIDTH:0]   upperExt;
    logic [WIDTH:0]   mcandExt;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    prodStep;
    logic [WIDTH:0]   signField;
    logic             lastIter;

    // Datapath for one Booth step. The extra sum bit keeps the carry out of -M when
    // M is the most-negative value, and becomes the replicated sign after the shift.
    always_comb begin
        upperExt = {prodQ[PW-1], prodQ[PW-1:WIDTH+1]};
        mcandExt = {mcandQ[WIDTH-1], mcandQ};
        unique case (prodQ[1:0])
            2'b01:   sum = upperExt + mcandExt;
            2'b10:   sum = upperExt - mcandExt;
            default: sum = upperExt;
        endcase
        prodStep  = {sum, prodQ[WIDTH:1]};
        signField = prodStep[PW-1:WIDTH];
        lastIter  = (cntQ == CNT_W'(WIDTH - 1));
    end

    always_comb begin
        stateD  = stateQ;
        cntD    = cntQ;
        prodD   = prodQ;
        mcandD  = mcandQ;
        resultD = resultQ;
        excD    = excQ;
        if (ctrl_MULT) begin
            // A start always wins, aborting whatever was in flight.
            mcandD  = data_operandA;
            prodD   = {{WIDTH{1'b0}}, data_operandB, 1'b0};
            cntD    = '0;
            resultD = '0;
            excD    = 1'b0;
            stateD  = StRun;
        end else begin
            case (stateQ)
                StRun: begin
                    prodD = prodStep;
                    cntD  = cntQ + 1'b1;
                    if (lastIter) begin
                        stateD  = StDone;
                        resultD = prodStep[WIDTH:1];
                        excD    = !((&signField) || !(|signField));
                    end
                end
                StDone:  stateD = StIdle;
                default: stateD = stateQ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ  <= StIdle;
            cntQ    <= '0;
            prodQ   <= '0;
            mcandQ  <= '0;
            resultQ <= '0;
            excQ    <= 1'b0;
        end else begin
            stateQ  <= stateD;
            cntQ    <= cntD;
            prodQ   <= prodD;
            mcandQ  <= mcandD;
            resultQ <= resultD;
            excQ    <= excD;
        end
    end

    assign busy           = (stateQ == StRun);
    assign data_resultRDY = (stateQ == StDone);
    assign data_result    = resultQ;
    assign data_exception = excQ;

endmodule

// File: tb/tb_booth_mult_iter.sv
// Self-checking bench for booth_mult_iter: a cycle-timed arithmetic model checked every
// cycle, plus directed cases with hand-computed expectations.
module tb_booth_mult_iter;

    localparam int unsigned WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             ctrl_MULT = 1'b0;
    logic [WIDTH-1:0] opA = '0;
    logic [WIDTH-1:0] opB = '0;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    booth_mult_iter #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (opA),
        .data_operandB  (opB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: edges elapsed since the last accepted start (-1 = nothing pending).
    int               k = -1;
    logic [WIDTH-1:0] mA = '0;
    logic [WIDTH-1:0] mB = '0;
    logic [WIDTH-1:0] expResult = '0;
    logic             expExc = 1'b0;
    logic signed [63:0] prod;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            k = -1;
            expResult = '0;
            expExc = 1'b0;
        end else if (ctrl_MULT) begin
            mA = opA;
            mB = opB;
            k = 0;
            expResult = '0;
            expExc = 1'b0;
        end else if (k >= 0 && k <= WIDTH) begin
            k++;
            if (k == WIDTH) begin
                prod = 64'($signed(mA)) * 64'($signed(mB));
                expResult = prod[31:0];
                expExc = (prod != {{32{prod[31]}}, prod[31:0]});
            end
        end
    end

    always @(negedge clock) begin
        check("busy", 64'(busy), 64'(k >= 0 && k < WIDTH));
        check("rdy", 64'(data_resultRDY), 64'(k == WIDTH));
        check("result", 64'(data_result), 64'(expResult));
        check("exception", 64'(data_exception), 64'(expExc));
    end

    task automatic startOp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        @(posedge clock);
        #1;
        opA = x;
        opB = y;
        ctrl_MULT = 1'b1;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        opA = $urandom;
        opB = $urandom;
    endtask

    // Counts edges from the start edge until RDY; bounded so a dead DUT cannot hang.
    task automatic waitRdy(output int n);
        n = 0;
        while (!data_resultRDY && n < 45) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    task automatic runOp(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic [WIDTH-1:0] er, input logic ee);
        int n;
        startOp(x, y);
        waitRdy(n);
        check({name, " latency"}, 64'(n), 64'(WIDTH));
        check({name, " result"}, 64'(data_result), 64'(er));
        check({name, " exception"}, 64'(data_exception), 64'(ee));
        @(posedge clock);
        #1;
        check({name, " rdy pulse width"}, 64'(data_resultRDY), 64'(0));
    endtask

    logic [WIDTH-1:0] special [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                                      32'h7FFF_FFFF, 32'h0001_0000};

    function automatic logic [WIDTH-1:0] pick();
        if ($urandom_range(0, 3) == 0) return special[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        int n;
        int pulses;
        repeat (2) @(posedge clock);
        #1;
        check("reset result", 64'(data_result), 64'(0));
        check("reset rdy", 64'(data_resultRDY), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        reset = 1'b1;

        runOp("3x4", 32'd3, 32'd4, 32'd12, 1'b0);
        runOp("-7x6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0);
        runOp("0xmax", 32'h0, 32'h7FFF_FFFF, 32'h0, 1'b0);
        runOp("minx-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        runOp("2^16sq", 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
        runOp("maxsq", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
        runOp("-1x-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0);
        runOp("minxmin", 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b1);

        // Restart mid-operation: only the second product may appear.
        startOp(32'd5, 32'd5);
        repeat (9) @(posedge clock);
        startOp(32'd2, 32'd9);
        waitRdy(n);
        check("restart latency", 64'(n), 64'(WIDTH));
        check("restart result", 64'(data_result), 64'(18));

        // Asynchronous reset during iteration 15.
        startOp(32'd123, 32'd456);
        repeat (14) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("async reset busy", 64'(busy), 64'(0));
        check("async reset result", 64'(data_result), 64'(0));
        @(posedge clock);
        #1;
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        check("no rdy after reset", 64'(pulses), 64'(0));
        runOp("6x7", 32'd6, 32'd7, 32'd42, 1'b0);

        // Random operands with random restart spacing, including aborts and DONE restarts.
        for (int i = 0; i < 250; i++) begin
            startOp(pick(), pick());
            repeat ($urandom_range(1, 38)) @(posedge clock);
        end
        repeat (40) @(posedge clock);
        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
